pc_flow_ctrl: RTL and testbench

PC_FLOW_CTRL -- requirements
Module: pc_flow_ctrl

---
 rtl/pc_flow_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pc_flow_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_flow_ctrl.sv
// rtl/pc_flow_ctrl.sv - program-counter flow controller: control-flow decode, return stack, run/halt/fault FSM
module pc_flow_ctrl #(
    parameter int STACK_DEPTH = 4,
    parameter int AW          = 10
) (
    input  logic                         clk,
    input  logic                         start_n,
    input  logic                         go,
    input  logic                         instr_valid,
    input  logic [3:0]                   cf_op,
    input  logic                         zero,
    input  logic [AW-1:0]                rp,
    output logic                         pc_start,
    output logic                         branch,
    output logic                         bizr,
    output logic                         bnzr,
    output logic                         jizr,
    output logic                         jnzr,
    output logic                         jump2sub,
    output logic                         retFsub,
    output logic                         lj0,
    output logic                         lj1,
    output logic                         lj2,
    output logic                         lj3,
    output logic [AW-1:0]                rl,
    output logic                         running,
    output logic                         done,
    output logic                         fault,
    output logic [1:0]                   fault_code,
    output logic [$clog2(STACK_DEPTH):0] sp,
    output logic [15:0]                  retired
);

    localparam int SPW = $clog2(STACK_DEPTH);
    localparam logic [SPW:0] SP_FULL = (SPW+1)'(STACK_DEPTH);

    localparam logic [3:0] OP_BIZR = 4'd1;
    localparam logic [3:0] OP_BNZR = 4'd2;
    localparam logic [3:0] OP_JIZR = 4'd3;
    localparam logic [3:0] OP_JNZR = 4'd4;
    localparam logic [3:0] OP_CALL = 4'd5;
    localparam logic [3:0] OP_RET  = 4'd6;
    localparam logic [3:0] OP_LJ0  = 4'd8;
    localparam logic [3:0] OP_LJ1  = 4'd9;
    localparam logic [3:0] OP_LJ2  = 4'd10;
    localparam logic [3:0] OP_LJ3  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]  stack [STACK_DEPTH];
    logic [SPW-1:0] top_idx;
    logic           launch;
    logic           push;
    logic           pop;
    logic           ovf;
    logic           unf;
    logic           count;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        ovf       = 1'b0;
        unf       = 1'b0;
        count     = 1'b0;
        branch    = 1'b0;
        bizr      = 1'b0;
        bnzr      = 1'b0;
        jizr      = 1'b0;
        jnzr      = 1'b0;
        jump2sub  = 1'b0;
        retFsub   = 1'b0;
        lj0       = 1'b0;
        lj1       = 1'b0;
        lj2       = 1'b0;
        lj3       = 1'b0;
        case (state)
            S_IDLE, S_HALT, S_FAULT: begin
                if (go) begin
                    state_nxt = S_LAUNCH;
                    launch    = 1'b1;
                end
            end
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN: begin
                if (instr_valid) begin
                    count = 1'b1;
                    case (cf_op)
                        OP_BIZR: if (zero) begin
                            branch = 1'b1;
                            bizr   = 1'b1;
                        end
                        OP_BNZR: if (!zero) begin
                            branch = 1'b1;
                            bnzr   = 1'b1;
                        end
                        OP_JIZR: if (zero) begin
                            branch = 1'b1;
                            jizr   = 1'b1;
                        end
                        OP_JNZR: if (!zero) begin
                            branch = 1'b1;
                            jnzr   = 1'b1;
                        end
                        OP_CALL: begin
                            // A call that would overflow faults instead of retiring
                            if (sp == SP_FULL) begin
                                ovf       = 1'b1;
                                count     = 1'b0;
                                state_nxt = S_FAULT;
                            end else begin
                                jump2sub = 1'b1;
                                push     = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (sp == '0) begin
                                unf       = 1'b1;
                                count     = 1'b0;
                                state_nxt = S_FAULT;
                            end else begin
                                retFsub = 1'b1;
                                pop     = 1'b1;
                            end
                        end
                        OP_LJ0:  lj0 = 1'b1;
                        OP_LJ1:  lj1 = 1'b1;
                        OP_LJ2:  lj2 = 1'b1;
                        OP_LJ3:  lj3 = 1'b1;
                        OP_HALT: state_nxt = S_HALT;
                        default: ;
                    endcase
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            sp         <= '0;
            retired    <= '0;
            fault_code <= 2'b00;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (launch) begin
            sp         <= '0;
            retired    <= '0;
            fault_code <= 2'b00;
        end else begin
            if (push) begin
                stack[sp[SPW-1:0]] <= rp + AW'(1);
                sp                 <= sp + (SPW+1)'(1);
            end
            if (pop) begin
                sp <= sp - (SPW+1)'(1);
            end
            if (ovf) begin
                fault_code <= 2'b01;
            end
            if (unf) begin
                fault_code <= 2'b10;
            end
            if (count) begin
                retired <= retired + 16'd1;
            end
        end
    end

    // When full, the low bits of sp wrap to 0 so top_idx lands on the last entry
    assign top_idx  = sp[SPW-1:0] - SPW'(1);
    assign rl       = (sp == '0) ? '0 : stack[top_idx];

    assign pc_start = (state != S_RUN);
    assign running  = (state == S_RUN);
    assign done     = (state == S_HALT);
    assign fault    = (state == S_FAULT);

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb/tb_pc_flow_ctrl.sv - self-checking bench for pc_flow_ctrl against a queue-based reference model
module tb_pc_flow_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic          clk;
    logic          start_n;
    logic          go;
    logic          instr_valid;
    logic [3:0]    cf_op;
    logic          zero;
    logic [AW-1:0] rp;
    logic          pc_start;
    logic          branch, bizr, bnzr, jizr, jnzr;
    logic          jump2sub, retFsub;
    logic          lj0, lj1, lj2, lj3;
    logic [AW-1:0] rl;
    logic          running, done, fault;
    logic [1:0]    fault_code;
    logic [2:0]    sp;
    logic [15:0]   retired;

    pc_flow_ctrl #(.STACK_DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .start_n    (start_n),
        .go         (go),
        .instr_valid(instr_valid),
        .cf_op      (cf_op),
        .zero       (zero),
        .rp         (rp),
        .pc_start   (pc_start),
        .branch     (branch),
        .bizr       (bizr),
        .bnzr       (bnzr),
        .jizr       (jizr),
        .jnzr       (jnzr),
        .jump2sub   (jump2sub),
        .retFsub    (retFsub),
        .lj0        (lj0),
        .lj1        (lj1),
        .lj2        (lj2),
        .lj3        (lj3),
        .rl         (rl),
        .running    (running),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .sp         (sp),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 idle, 1 launch, 2 run, 3 halt, 4 fault
    int            m_state;
    logic [AW-1:0] m_stack [$];
    logic [15:0]   m_retired;
    logic [1:0]    m_fcode;

    logic [10:0] strobes;
    assign strobes = {branch, bizr, bnzr, jizr, jnzr, jump2sub, retFsub, lj0, lj1, lj2, lj3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] m_rl();
        if (m_stack.size() == 0) return '0;
        return m_stack[m_stack.size()-1];
    endfunction

    function automatic logic [10:0] m_strobes(input logic v, input logic [3:0] op, input logic z);
        logic [10:0] e;
        e = '0;
        if (m_state == 2 && v) begin
            case (op)
                4'd1: if (z)  begin e[10] = 1'b1; e[9] = 1'b1; end
                4'd2: if (!z) begin e[10] = 1'b1; e[8] = 1'b1; end
                4'd3: if (z)  begin e[10] = 1'b1; e[7] = 1'b1; end
                4'd4: if (!z) begin e[10] = 1'b1; e[6] = 1'b1; end
                4'd5: if (m_stack.size() < DEPTH) e[5] = 1'b1;
                4'd6: if (m_stack.size() > 0) e[4] = 1'b1;
                4'd8, 4'd9, 4'd10, 4'd11: e[11 - int'(op)] = 1'b1;
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic m_reset();
        m_state   = 0;
        m_stack.delete();
        m_retired = '0;
        m_fcode   = 2'b00;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "/flags"}, 32'({pc_start, running, done, fault}),
            32'({m_state != 2, m_state == 2, m_state == 3, m_state == 4}));
        chk({tag, "/fault_code"}, 32'(fault_code), 32'(m_fcode));
        chk({tag, "/sp"}, 32'(sp), 32'(m_stack.size()));
        chk({tag, "/retired"}, 32'(retired), 32'(m_retired));
        chk({tag, "/rl"}, 32'(rl), 32'(m_rl()));
    endtask

    // One clock: drive, check combinational decode, clock, advance model, check registered state
    task automatic cycle(input logic g, input logic v, input logic [3:0] op, input logic z,
                         input logic [AW-1:0] r, input string tag);
        logic [AW-1:0] ret_addr;
        go = g; instr_valid = v; cf_op = op; zero = z; rp = r;
        #1;
        chk({tag, "/strobes"}, 32'(strobes), 32'(m_strobes(v, op, z)));
        chk({tag, "/rl_pre"}, 32'(rl), 32'(m_rl()));
        @(posedge clk);
        #1;
        case (m_state)
            0, 3, 4: if (g) begin
                m_state = 1;
                m_stack.delete();
                m_retired = '0;
                m_fcode = 2'b00;
            end
            1: m_state = 2;
            2: if (v) begin
                if (op == 4'd5 && m_stack.size() == DEPTH) begin
                    m_state = 4;
                    m_fcode = 2'b01;
                end else if (op == 4'd6 && m_stack.size() == 0) begin
                    m_state = 4;
                    m_fcode = 2'b10;
                end else begin
                    if (op == 4'd5) begin
                        ret_addr = r + 1'b1;
                        m_stack.push_back(ret_addr);
                    end
                    if (op == 4'd6) void'(m_stack.pop_back());
                    if (op == 4'd15) m_state = 3;
                    m_retired = m_retired + 1'b1;
                end
            end
            default: ;
        endcase
        check_state(tag);
    endtask

    initial begin
        logic          g, v, z;
        logic [3:0]    op;
        logic [AW-1:0] r;

        start_n = 1'b0; go = 1'b0; instr_valid = 1'b0; cf_op = '0; zero = 1'b0; rp = '0;
        m_reset();
        #2;
        chk("reset/strobes", 32'(strobes), 32'd0);
        check_state("reset");
        @(posedge clk); #1;
        start_n = 1'b1;

        cycle(0, 1, 4'd1, 1, 10'h010, "idle_hold");
        cycle(1, 0, 4'd0, 0, 10'h000, "go");
        cycle(1, 1, 4'd5, 0, 10'h000, "launch");
        cycle(0, 1, 4'd1, 1, 10'h020, "bizr_taken");
        cycle(0, 1, 4'd2, 1, 10'h021, "bnzr_not_taken");
        cycle(0, 1, 4'd4, 0, 10'h022, "jnzr_taken");
        cycle(0, 1, 4'd5, 0, 10'h3FF, "call_3ff");
        cycle(0, 1, 4'd6, 0, 10'h000, "ret");
        for (int i = 0; i < 5; i++) cycle(0, 1, 4'd5, 0, AW'(10'h100 + i), "call_chain");
        cycle(0, 0, 4'd0, 0, 10'h000, "fault_hold");
        cycle(1, 0, 4'd0, 0, 10'h000, "go_after_ovf");
        cycle(0, 0, 4'd0, 0, 10'h000, "launch2");
        cycle(0, 1, 4'd6, 0, 10'h050, "ret_empty");
        cycle(1, 0, 4'd0, 0, 10'h000, "go_after_unf");
        cycle(0, 0, 4'd0, 0, 10'h000, "launch3");
        cycle(0, 1, 4'd9, 0, 10'h060, "lj1");
        cycle(0, 1, 4'd15, 0, 10'h061, "halt");
        cycle(0, 1, 4'd7, 0, 10'h062, "halted_ignore");

        for (int i = 0; i < 600; i++) begin
            g  = ($urandom_range(0, 3) == 0);
            v  = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            if (op == 4'd15 && $urandom_range(0, 3) != 0) op = 4'd5;
            z  = 1'($urandom_range(0, 1));
            r  = AW'($urandom);
            cycle(g, v, op, z, r, "rand");
        end

        if (m_state == 2) cycle(0, 1, 4'd15, 0, 10'h000, "pre_rst_halt");
        cycle(1, 0, 4'd0, 0, 10'h000, "pre_rst_go");
        cycle(0, 0, 4'd0, 0, 10'h000, "pre_rst_launch");
        for (int i = 0; i < 3; i++) cycle(0, 1, 4'd5, 0, AW'(10'h200 + i), "pre_rst_call");
        go = 1'b0; instr_valid = 1'b1; cf_op = 4'd5; zero = 1'b0; rp = 10'h2FF;
        start_n = 1'b0;
        #1;
        m_reset();
        chk("async_rst/strobes", 32'(strobes), 32'd0);
        check_state("async_rst");
        @(posedge clk); #1;
        start_n = 1'b1;
        check_state("rst_released");
        cycle(0, 1, 4'd5, 0, 10'h010, "post_rst_idle");
        cycle(1, 0, 4'd0, 0, 10'h000, "post_rst_go");
        cycle(0, 0, 4'd0, 0, 10'h000, "post_rst_launch");
        cycle(0, 1, 4'd6, 0, 10'h000, "post_rst_ret_empty");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
